// File: rtl/load_unit.sv
// Data-memory load unit: issues one word read, then extracts and extends the
// byte/half/word result, with misalignment, illegal-type and timeout detection.
module load_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [2:0]  funct3,
    output logic        busy,
    output logic        memReqValid,
    input  logic        memReqReady,
    output logic [31:0] memReqAddr,
    input  logic        memRespValid,
    input  logic [31:0] memRespData,
    output logic [31:0] dmemOut,
    output logic        done,
    output logic        loadError
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    state_t      state_r;
    logic [1:0]  addr_lo_r;
    logic [2:0]  funct3_r;
    logic [15:0] cnt_r;
    logic        busy_r;
    logic        req_valid_r;
    logic [31:0] req_addr_r;
    logic [31:0] dmem_r;
    logic        done_r;
    logic        error_r;
    logic        accept_s;

    function automatic logic load_ok(input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        case (f3)
            3'b000, 3'b100: ok = 1'b1;
            3'b001, 3'b101: ok = (lo[0] == 1'b0);
            3'b010:         ok = (lo == 2'b00);
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            2'b11:   b = word[31:24];
            default: b = 8'h00;
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Legality of the request presented with start.
    always_comb begin
        accept_s = 1'b0;
        if (start) begin
            accept_s = load_ok(funct3, addr[1:0]);
        end else begin
            accept_s = 1'b0;
        end
    end

    // Load sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            addr_lo_r   <= 2'b00;
            funct3_r    <= 3'b000;
            cnt_r       <= 16'h0000;
            busy_r      <= 1'b0;
            req_valid_r <= 1'b0;
            req_addr_r  <= 32'h0000_0000;
            dmem_r      <= 32'h0000_0000;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        addr_lo_r  <= addr[1:0];
                        funct3_r   <= funct3;
                        req_addr_r <= {addr[31:2], 2'b00};
                        busy_r     <= 1'b1;
                        if (accept_s) begin
                            req_valid_r <= 1'b1;
                            state_r     <= REQ;
                        end else begin
                            dmem_r  <= 32'h0000_0000;
                            done_r  <= 1'b1;
                            error_r <= 1'b1;
                            state_r <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (memReqReady) begin
                        req_valid_r <= 1'b0;
                        cnt_r       <= 16'h0000;
                        state_r     <= WAIT;
                    end
                end
                WAIT: begin
                    // A response in the final timeout cycle still completes normally.
                    if (memRespValid) begin
                        dmem_r  <= extend(funct3_r, addr_lo_r, memRespData);
                        done_r  <= 1'b1;
                        error_r <= 1'b0;
                        state_r <= DONE;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        dmem_r  <= 32'h0000_0000;
                        done_r  <= 1'b1;
                        error_r <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    error_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    req_valid_r <= 1'b0;
                    done_r      <= 1'b0;
                    error_r     <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign memReqValid = req_valid_r;
    assign memReqAddr  = req_addr_r;
    assign dmemOut     = dmem_r;
    assign done        = done_r;
    assign loadError   = error_r;

endmodule

// File: tb/tb_load_unit.sv
// Directed-vector bench for load_unit with hand-computed expected results.
module tb_load_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic        busy;
    logic        memReqValid;
    logic        memReqReady;
    logic [31:0] memReqAddr;
    logic        memRespValid;
    logic [31:0] memRespData;
    logic [31:0] dmemOut;
    logic        done;
    logic        loadError;

    int vec_cnt = 0;
    int err_cnt = 0;

    load_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .funct3(funct3),
        .busy(busy), .memReqValid(memReqValid), .memReqReady(memReqReady),
        .memReqAddr(memReqAddr), .memRespValid(memRespValid), .memRespData(memRespData),
        .dmemOut(dmemOut), .done(done), .loadError(loadError)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Legal load: ready after rdly cycles, response after wdly idle WAIT cycles.
    task automatic legal_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                              input int rdly, input int wdly, input logic [31:0] data,
                              input logic [31:0] exp);
        start = 1'b1; addr = a; funct3 = f3;
        tick();
        start = 1'b0;
        check({tag, "_reqv"}, 32'(memReqValid), 32'd1);
        check({tag, "_reqa"}, memReqAddr, {a[31:2], 2'b00});
        for (int i = 0; i < rdly; i++) begin
            start = 1'b1; addr = 32'hFFFF_FFF0; funct3 = 3'b010;
            tick();
            start = 1'b0;
            check({tag, "_reqv_hold"}, 32'(memReqValid), 32'd1);
            check({tag, "_reqa_hold"}, memReqAddr, {a[31:2], 2'b00});
        end
        memReqReady = 1'b1;
        tick();
        memReqReady = 1'b0;
        check({tag, "_reqv_drop"}, 32'(memReqValid), 32'd0);
        for (int i = 0; i < wdly; i++) begin
            tick();
            check({tag, "_wait_busy"}, {30'd0, busy, done}, 32'd2);
        end
        memRespValid = 1'b1; memRespData = data;
        tick();
        memRespValid = 1'b0; memRespData = 32'h0;
        check({tag, "_done"}, {30'd0, done, loadError}, 32'd2);
        check({tag, "_data"}, dmemOut, exp);
        start = 1'b1; addr = 32'h0000_0001; funct3 = 3'b111;
        tick();
        start = 1'b0;
        check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
        check({tag, "_hold"}, dmemOut, exp);
    endtask

    // Rejected load: error completion one cycle after start, no request.
    task automatic bad_load(input string tag, input logic [2:0] f3, input logic [31:0] a);
        start = 1'b1; addr = a; funct3 = f3;
        tick();
        start = 1'b0;
        check({tag, "_done_err"}, {30'd0, done, loadError}, 32'd3);
        check({tag, "_noreq"}, 32'(memReqValid), 32'd0);
        check({tag, "_data0"}, dmemOut, 32'h0);
        tick();
        check({tag, "_idle"}, {29'd0, busy, done, memReqValid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; addr = 32'h0; funct3 = 3'b000;
        memReqReady = 1'b0; memRespValid = 1'b0; memRespData = 32'h0;
        tick(); tick();
        check("rst_outs", {28'd0, busy, memReqValid, done, loadError}, 32'd0);
        check("rst_addr", memReqAddr, 32'h0);
        check("rst_data", dmemOut, 32'h0);
        rst = 1'b0;
        tick();

        legal_load("lb",  3'b000, 32'h0000_1003, 0, 0, 32'h80FF_FF00, 32'hFFFF_FF80);
        legal_load("lhu", 3'b101, 32'h0000_2002, 0, 1, 32'h9ABC_1234, 32'h0000_9ABC);
        legal_load("lh",  3'b001, 32'h0000_2002, 1, 0, 32'h9ABC_1234, 32'hFFFF_9ABC);
        legal_load("lh0", 3'b001, 32'h0000_2000, 0, 0, 32'h9ABC_1234, 32'h0000_1234);
        legal_load("lbu", 3'b100, 32'h0000_1001, 0, 2, 32'h80FF_FF00, 32'h0000_00FF);
        legal_load("lw",  3'b010, 32'h0000_0010, 5, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        bad_load("lw_mis",  3'b010, 32'h0000_0006);
        bad_load("f3_011",  3'b011, 32'h0000_0006);
        bad_load("f3_110",  3'b110, 32'h0000_0000);
        bad_load("lhu_mis", 3'b101, 32'h0000_2001);

        // Response pulse while idle must not disturb anything.
        memRespValid = 1'b1; memRespData = 32'h1234_5678;
        tick();
        memRespValid = 1'b0;
        check("idle_resp", {30'd0, busy, done}, 32'd0);
        check("idle_resp_data", dmemOut, 32'h0);

        // Timeout after exactly four WAIT cycles.
        start = 1'b1; addr = 32'h0000_0040; funct3 = 3'b010;
        tick();
        start = 1'b0; memReqReady = 1'b1;
        tick();
        memReqReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_waiting", {30'd0, busy, done}, 32'd2);
        end
        tick();
        check("to_done_err", {30'd0, done, loadError}, 32'd3);
        check("to_data0", dmemOut, 32'h0);
        tick();
        check("to_idle", 32'(busy), 32'd0);

        legal_load("to_last", 3'b010, 32'h0000_0044, 0, 3, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // Reset during WAIT, then a stale response after release.
        start = 1'b1; addr = 32'h0000_0010; funct3 = 3'b010;
        tick();
        start = 1'b0; memReqReady = 1'b1;
        tick();
        memReqReady = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_outs", {28'd0, busy, memReqValid, done, loadError}, 32'd0);
        check("mid_rst_data", {dmemOut | memReqAddr}, 32'h0);
        tick();
        rst = 1'b0;
        memRespValid = 1'b1; memRespData = 32'hFFFF_FFFF;
        tick();
        memRespValid = 1'b0;
        check("late_resp", {30'd0, busy, done}, 32'd0);
        check("late_resp_data", dmemOut, 32'h0);
        tick();
        check("late_resp_nodone", 32'(done), 32'd0);

        legal_load("post_rst", 3'b000, 32'h0000_0011, 0, 0, 32'h0000_7F00, 32'h0000_007F);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, WAIT-state cycles without a response before the load aborts (range 1..65535).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  load request; sampled only in IDLE.
REQ-005 addr  input  32  byte address of the load; captured with start.
REQ-006 funct3  input  3  load type; captured with start: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 memReqValid  output  1  data-memory read request valid.
REQ-009 memReqReady  input  1  memory accepts the request.
REQ-010 memReqAddr  output  32  word-aligned request address, {addr[31:2],2'b00}.
REQ-011 memRespValid  input  1  read data valid, one-cycle pulse.
REQ-012 memRespData  input  32  read word.
REQ-013 dmemOut  output  32  extended load result to the regfile write-back mux.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 loadError  output  1  valid with done; 1 = misaligned, illegal funct3, or timeout.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, DONE.
REQ-017 IDLE: start=1 captures addr/funct3; next state REQ if legal and aligned, else DONE with loadError=1.
REQ-018 Misaligned: LH/LHU with addr[0]=1; LW with addr[1:0]!=0; illegal funct3: 011, 110, 111.
REQ-019 Error path: no memory request issued; dmemOut=0; done one cycle after start.
REQ-020 REQ: memReqValid=1, memReqAddr stable; held until memReqReady=1, then WAIT.
REQ-021 memReqValid SHALL be driven from state only, with no combinational dependency on memReqReady.
REQ-022 WAIT: timeout counter cleared on entry, increments each cycle without memRespValid.
REQ-023 WAIT + memRespValid=1: register extended result into dmemOut; next state DONE, loadError=0.
REQ-024 WAIT: counter reaching TIMEOUT_CYCLES with no response -> DONE, loadError=1, dmemOut=0.
REQ-025 Response and timeout in the same cycle: the response wins.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE; start in DONE is ignored.
REQ-027 Byte select: memRespData[8*addr[1:0]+:8]; half select: memRespData[16*addr[1]+:16].
REQ-028 LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word unchanged.
REQ-029 dmemOut holds its value from DONE until the next completion.
REQ-030 memRespValid in IDLE, REQ or DONE is ignored and changes no state.
REQ-031 start while busy=1 is ignored; no queueing.
REQ-032 Minimum latency for a legal load with ready and response immediate: start at cycle 0, REQ 1, WAIT 2, DONE 3.

Reset
REQ-033 rst=1 immediately forces state IDLE, busy=0, memReqValid=0, memReqAddr=0, dmemOut=0, done=0, loadError=0, counter=0.
REQ-034 Reset mid-operation (REQ or WAIT) abandons the load, with no done pulse; a late response after reset release is ignored.

Verification
REQ-035 LB, addr=0x1003, response 0x80FF_FF00 -> memReqAddr=0x1000, dmemOut=0xFFFF_FF80, done=1, loadError=0.
REQ-036 LHU, addr=0x2002, response 0x9ABC_1234 -> dmemOut=0x0000_9ABC; LH with the same stimulus -> 0xFFFF_9ABC.
REQ-037 LW, addr=0x0006 -> no memReqValid, done one cycle after start, loadError=1, dmemOut=0; funct3=011 gives the same result.
REQ-038 LW, addr=0x10, memReqReady low 5 cycles -> memReqValid and memReqAddr=0x10 stable throughout; response 0xDEAD_BEEF -> dmemOut=0xDEAD_BEEF.
REQ-039 TIMEOUT_CYCLES=4 with no response -> done with loadError=1 after 4 WAIT cycles; second run with response on the 4th cycle -> loadError=0.
REQ-040 rst asserted during WAIT, then response pulse after release -> all outputs 0, no done; next start completes normally.
